// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-input stream arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/stream_out_reg.sv
// Single-stage registered output slot with valid/ready handshake.
module stream_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last
);

    logic [DATA_WIDTH-1:0] data_r;
    logic                  valid_r;
    logic                  last_r;

    // Load on accept; otherwise drop valid once downstream takes the beat.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            data_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (load) begin
            data_r  <= in_data;
            valid_r <= 1'b1;
            last_r  <= in_last;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign out_data  = data_r;
    assign out_valid = valid_r;
    assign out_last  = last_r;

endmodule

// File: rtl/mux2_stream_arb.sv
// Round-robin burst arbiter for two valid/ready streams; drives the mux select
// and a registered copy of the granted stream.
module mux2_stream_arb
    import mux_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  a_valid,
    input  logic                  a_last,
    output logic                  a_ready,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  b_valid,
    input  logic                  b_last,
    output logic                  b_ready,
    output logic                  sel,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int               CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    arb_state_t            state_r;
    logic                  prio_r;
    logic                  sel_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic                  slot_free_s;
    logic                  a_ready_s;
    logic                  b_ready_s;
    logic                  a_acc_s;
    logic                  b_acc_s;
    logic                  load_s;
    logic [DATA_WIDTH-1:0] load_data_s;
    logic                  load_last_s;

    assign slot_free_s = !out_valid || out_ready;
    assign cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Readies follow the grant; held low while reset is asserted so no beat is lost.
    always_comb begin
        a_ready_s = 1'b0;
        b_ready_s = 1'b0;
        if (sys_rst) begin
            case (state_r)
                GRANT_A: a_ready_s = slot_free_s;
                GRANT_B: b_ready_s = slot_free_s;
                default: begin
                    a_ready_s = 1'b0;
                    b_ready_s = 1'b0;
                end
            endcase
        end else begin
            a_ready_s = 1'b0;
            b_ready_s = 1'b0;
        end
    end

    assign a_acc_s = a_valid && a_ready_s;
    assign b_acc_s = b_valid && b_ready_s;
    assign load_s  = a_acc_s || b_acc_s;

    // Route the accepted beat into the output slot.
    always_comb begin
        load_data_s = a_data;
        load_last_s = a_last;
        if (b_acc_s) begin
            load_data_s = b_data;
            load_last_s = b_last;
        end else begin
            load_data_s = a_data;
            load_last_s = a_last;
        end
    end

    // Grant FSM with priority hand-off and burst counter; a burst cap ends the
    // grant without touching out_last so the packet continues on a later grant.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_r <= IDLE;
            prio_r  <= SEL_A;
            sel_r   <= SEL_A;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (a_valid && (!b_valid || prio_r == SEL_A)) begin
                        state_r <= GRANT_A;
                        sel_r   <= SEL_A;
                        cnt_r   <= '0;
                    end else if (b_valid) begin
                        state_r <= GRANT_B;
                        sel_r   <= SEL_B;
                        cnt_r   <= '0;
                    end
                end
                GRANT_A: begin
                    if (a_acc_s) begin
                        cnt_r <= cnt_nxt_s;
                        if (a_last || cnt_nxt_s == CNT_MAX) begin
                            state_r <= IDLE;
                            prio_r  <= SEL_B;
                        end
                    end
                end
                GRANT_B: begin
                    if (b_acc_s) begin
                        cnt_r <= cnt_nxt_s;
                        if (b_last || cnt_nxt_s == CNT_MAX) begin
                            state_r <= IDLE;
                            prio_r  <= SEL_A;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    stream_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .load      (load_s),
        .in_data   (load_data_s),
        .in_last   (load_last_s),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    assign a_ready = a_ready_s;
    assign b_ready = b_ready_s;
    assign sel     = sel_r;

endmodule
